// File: rtl/gon_pkg.sv
// Shared types and default sizing for the GON tag scheduler.
package gon_pkg;

    localparam int GON_ID_SIZE  = 8;
    localparam int GON_NUM_DST  = 6;
    localparam int GON_LEN_BITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } gon_sched_state_e;

endpackage

// File: rtl/gon_tag_scheduler.sv
// GON bus sequencer: sweeps per-destination IDs into the multicast controllers,
// then forwards tagged jobs of exactly len source beats onto the shared bus.
module gon_tag_scheduler
    import gon_pkg::*;
#(
    parameter int ID_SIZE  = GON_ID_SIZE,
    parameter int NUM_DST  = GON_NUM_DST,
    parameter int LEN_BITS = GON_LEN_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic [NUM_DST*ID_SIZE-1:0] cfg_ids,
    output logic [NUM_DST-1:0]         set_id,
    output logic [ID_SIZE-1:0]         id_in,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [ID_SIZE-1:0]         job_tag,
    input  logic [LEN_BITS-1:0]        job_len,
    input  logic                       src_valid,
    output logic                       src_ready,
    output logic                       bus_valid,
    input  logic                       bus_ready,
    output logic [ID_SIZE-1:0]         tag,
    output logic                       busy,
    output logic                       job_done
);

    localparam int                 IDX_W    = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DST - 1);
    localparam logic [NUM_DST-1:0] ONE_HOT0 = NUM_DST'(1);

    gon_sched_state_e           state_r, state_nx;
    logic [IDX_W-1:0]           idx_r, idx_nx;
    logic [LEN_BITS-1:0]        cnt_r, cnt_nx;
    logic [LEN_BITS-1:0]        len_r, len_nx;
    logic [NUM_DST*ID_SIZE-1:0] cfg_lat_r, cfg_lat_nx;
    logic [NUM_DST-1:0]         set_id_r, set_id_nx;
    logic [ID_SIZE-1:0]         id_in_r, id_in_nx;
    logic [ID_SIZE-1:0]         tag_r, tag_nx;
    logic                       job_done_r, job_done_nx;
    logic                       beat_s;

    // The beat gate only opens in RUN, so nothing leaks past the last beat.
    assign beat_s    = (state_r == RUN) && src_valid && bus_ready;
    assign bus_valid = (state_r == RUN) && src_valid;
    assign src_ready = (state_r == RUN) && bus_ready;
    assign job_ready = (state_r == IDLE) && !cfg_start && !rst;
    assign busy      = (state_r != IDLE);
    assign set_id    = set_id_r;
    assign id_in     = id_in_r;
    assign tag       = tag_r;
    assign job_done  = job_done_r;

    // Next-state and next registered-output logic.
    always_comb begin
        state_nx    = state_r;
        idx_nx      = idx_r;
        cnt_nx      = cnt_r;
        len_nx      = len_r;
        cfg_lat_nx  = cfg_lat_r;
        set_id_nx   = '0;
        id_in_nx    = '0;
        tag_nx      = tag_r;
        job_done_nx = 1'b0;
        case (state_r)
            IDLE: begin
                if (cfg_start) begin
                    state_nx   = CFG;
                    cfg_lat_nx = cfg_ids;
                    idx_nx     = '0;
                    set_id_nx  = ONE_HOT0;
                    id_in_nx   = cfg_ids[0 +: ID_SIZE];
                end else if (job_valid) begin
                    tag_nx = job_tag;
                    len_nx = job_len;
                    cnt_nx = '0;
                    if (job_len == '0) begin
                        state_nx    = DONE;
                        job_done_nx = 1'b1;
                    end else begin
                        state_nx = RUN;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            CFG: begin
                if (idx_r == IDX_LAST) begin
                    state_nx = IDLE;
                end else begin
                    idx_nx    = idx_r + IDX_W'(1);
                    set_id_nx = ONE_HOT0 << idx_nx;
                    id_in_nx  = cfg_lat_r[idx_nx*ID_SIZE +: ID_SIZE];
                end
            end
            RUN: begin
                // Compare before increment so a full-scale length never wraps cnt.
                if (beat_s) begin
                    if (cnt_r == len_r - LEN_BITS'(1)) begin
                        state_nx    = DONE;
                        job_done_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt_r + LEN_BITS'(1);
                    end
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            cnt_r      <= '0;
            len_r      <= '0;
            cfg_lat_r  <= '0;
            set_id_r   <= '0;
            id_in_r    <= '0;
            tag_r      <= '0;
            job_done_r <= 1'b0;
        end else begin
            state_r    <= state_nx;
            idx_r      <= idx_nx;
            cnt_r      <= cnt_nx;
            len_r      <= len_nx;
            cfg_lat_r  <= cfg_lat_nx;
            set_id_r   <= set_id_nx;
            id_in_r    <= id_in_nx;
            tag_r      <= tag_nx;
            job_done_r <= job_done_nx;
        end
    end

endmodule

// File: tb/tb_gon_tag_scheduler.sv
// Directed and randomized bench for gon_tag_scheduler with a beat-counting job model
// and six multicast-controller ID models.
module tb_gon_tag_scheduler;

    localparam int ID = 8;
    localparam int ND = 6;
    localparam int LB = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_start;
    logic [ND*ID-1:0] cfg_ids;
    logic [ND-1:0]    set_id;
    logic [ID-1:0]    id_in;
    logic             job_valid;
    logic             job_ready;
    logic [ID-1:0]    job_tag;
    logic [LB-1:0]    job_len;
    logic             src_valid;
    logic             src_ready;
    logic             bus_valid;
    logic             bus_ready;
    logic [ID-1:0]    tag;
    logic             busy;
    logic             job_done;

    int vectors = 0;
    int miscompares = 0;
    logic [ID-1:0] ctrl_id [ND];
    bit pat [0:5];

    gon_tag_scheduler #(.ID_SIZE(ID), .NUM_DST(ND), .LEN_BITS(LB)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ids(cfg_ids),
        .set_id(set_id), .id_in(id_in), .job_valid(job_valid), .job_ready(job_ready),
        .job_tag(job_tag), .job_len(job_len), .src_valid(src_valid), .src_ready(src_ready),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .tag(tag), .busy(busy),
        .job_done(job_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        chk({name, "_set_id"}, 32'(set_id), 32'd0);
        chk({name, "_id_in"}, 32'(id_in), 32'd0);
        chk({name, "_tag"}, 32'(tag), 32'd0);
        chk({name, "_job_ready"}, 32'(job_ready), 32'd0);
        chk({name, "_src_ready"}, 32'(src_ready), 32'd0);
        chk({name, "_bus_valid"}, 32'(bus_valid), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_job_done"}, 32'(job_done), 32'd0);
    endtask

    // mode 0: random src/bus handshakes, 1: src always valid with bus_ready pattern,
    // 2: continuous handshake. Expected: exactly len beats, then a single done cycle.
    task automatic run_job(input logic [ID-1:0] t, input logic [LB-1:0] len, input int mode);
        int beats_in = 0;
        int beats_bus = 0;
        int cycles = 0;
        int budget = 8 * int'(len) + 64;
        job_valid = 1'b1;
        job_tag   = t;
        job_len   = len;
        #1;
        chk("job_ready_idle", 32'(job_ready), 32'd1);
        tick;
        job_valid = 1'b0;
        job_tag   = ~t;
        job_len   = '0;
        while (beats_in < int'(len) && cycles < budget) begin
            case (mode)
                0: begin
                    src_valid = 1'($urandom);
                    bus_ready = 1'($urandom);
                end
                1: begin
                    src_valid = 1'b1;
                    bus_ready = pat[cycles % 6];
                end
                default: begin
                    src_valid = 1'b1;
                    bus_ready = 1'b1;
                end
            endcase
            #1;
            chk("run_tag", 32'(tag), 32'(t));
            chk("run_bus_valid", 32'(bus_valid), 32'(src_valid));
            chk("run_src_ready", 32'(src_ready), 32'(bus_ready));
            chk("run_job_done", 32'(job_done), 32'd0);
            if (src_valid && bus_ready) beats_in++;
            if (bus_valid && bus_ready) beats_bus++;
            tick;
            cycles++;
        end
        chk("job_beats_forwarded", 32'(beats_bus), 32'(len));
        src_valid = 1'b1;
        bus_ready = 1'b1;
        #1;
        chk("done_pulse", 32'(job_done), 32'd1);
        chk("done_no_extra_beat", 32'(bus_valid), 32'd0);
        chk("done_src_ready", 32'(src_ready), 32'd0);
        chk("done_tag", 32'(tag), 32'(t));
        tick;
        chk("after_done_pulse", 32'(job_done), 32'd0);
        chk("after_done_busy", 32'(busy), 32'd0);
        chk("after_done_tag_hold", 32'(tag), 32'(t));
        src_valid = 1'b0;
        bus_ready = 1'b0;
    endtask

    initial begin
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < ND; i++) ctrl_id[i] = '0;
        rst = 1'b1; cfg_start = 1'b0; cfg_ids = '0; job_valid = 1'b0;
        job_tag = '0; job_len = '0; src_valid = 1'b0; bus_ready = 1'b0;
        #1;
        check_quiet("reset");
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("idle_job_ready", 32'(job_ready), 32'd1);

        // Configuration sweep with a job offered in the same cycle as cfg_start.
        for (int i = 0; i < ND; i++) cfg_ids[i*ID +: ID] = ID'(10 + i);
        cfg_start = 1'b1;
        job_valid = 1'b1;
        job_tag   = 8'd7;
        job_len   = 16'd2;
        #1;
        chk("cfg_priority_job_ready", 32'(job_ready), 32'd0);
        tick;
        cfg_start = 1'b0;
        cfg_ids   = '1;
        for (int k = 0; k < ND; k++) begin
            #1;
            chk("cfg_set_id", 32'(set_id), 32'(1) << k);
            chk("cfg_id_in", 32'(id_in), 32'(10 + k));
            chk("cfg_job_ready", 32'(job_ready), 32'd0);
            chk("cfg_busy", 32'(busy), 32'd1);
            for (int i = 0; i < ND; i++) if (set_id[i]) ctrl_id[i] = id_in;
            tick;
        end
        chk("cfg_end_set_id", 32'(set_id), 32'd0);
        chk("cfg_end_busy", 32'(busy), 32'd0);
        for (int i = 0; i < ND; i++) chk("ctrl_model_id", 32'(ctrl_id[i]), 32'(10 + i));
        run_job(8'd7, 16'd2, 2);

        // Toggling bus_ready pattern, then a zero-length job.
        run_job(8'd3, 16'd4, 1);
        job_valid = 1'b1;
        job_tag   = 8'd9;
        job_len   = 16'd0;
        #1;
        chk("len0_job_ready", 32'(job_ready), 32'd1);
        tick;
        job_valid = 1'b0;
        src_valid = 1'b1;
        bus_ready = 1'b1;
        #1;
        chk("len0_done", 32'(job_done), 32'd1);
        chk("len0_bus_valid", 32'(bus_valid), 32'd0);
        chk("len0_tag", 32'(tag), 32'd9);
        tick;
        chk("len0_done_clear", 32'(job_done), 32'd0);
        chk("len0_bus_valid_idle", 32'(bus_valid), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        src_valid = 1'b0;
        bus_ready = 1'b0;

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            run_job(ID'($urandom), LB'($urandom_range(0, 12)), 0);
        end

        // Asynchronous reset in the middle of a job after 3 of 8 beats.
        job_valid = 1'b1;
        job_tag   = 8'd5;
        job_len   = 16'd8;
        tick;
        job_valid = 1'b0;
        src_valid = 1'b1;
        bus_ready = 1'b1;
        tick;
        tick;
        tick;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_quiet("midrun_reset");
        tick;
        check_quiet("midrun_reset_edge");
        rst = 1'b0;
        src_valid = 1'b0;
        bus_ready = 1'b0;
        tick;
        chk("post_reset_job_done", 32'(job_done), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Full-scale length with continuous handshake.
        run_job(8'hA5, 16'hFFFF, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
